// File: rtl/instr_mem_loader.sv
// instr_mem_loader: multi-port instruction store with direct,
// burst and clear write paths arbitrated by a small FSM.
module instr_mem_loader #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 32,
  parameter int N_PORTS = 5,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_PORTS*ADDR_W-1:0]   rd_addr,
  output logic [N_PORTS*DATA_W-1:0]   rd_data,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_drop,
  input  logic                        load_start,
  input  logic [ADDR_W-1:0]           load_base,
  input  logic [ADDR_W:0]             load_len,
  input  logic                        load_valid,
  input  logic [DATA_W-1:0]           load_data,
  output logic                        load_ready,
  input  logic                        load_abort,
  input  logic                        clear_start,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CLEAR
  } stateT;

  stateT               state;
  stateT               nextState;
  logic [ADDR_W-1:0]   ptr;
  logic [ADDR_W-1:0]   ptrNext;
  logic [ADDR_W:0]     cnt;
  logic [ADDR_W:0]     cntNext;
  logic                doneNext;
  logic                dropNext;
  logic                memWe;
  logic [ADDR_W-1:0]   memWa;
  logic [DATA_W-1:0]   memWd;
  logic [DATA_W-1:0]   mem [DEPTH];

  // asynchronous read ports, no write bypass
  for (genvar p = 0; p < N_PORTS; p++) begin : gRd
    assign rd_data[p*DATA_W +: DATA_W] =
      mem[rd_addr[p*ADDR_W +: ADDR_W]];
  end

  // state-decoded handshake and status
  assign busy       = (state != IDLE);
  assign load_ready = (state == LOAD);

  // next-state, pointer/counter and single write-port mux
  always_comb begin
    nextState = state;
    ptrNext   = ptr;
    cntNext   = cnt;
    doneNext  = 1'b0;
    dropNext  = 1'b0;
    memWe     = 1'b0;
    memWa     = ptr;
    memWd     = load_data;
    unique case (state)
      IDLE: begin
        if (wr_en) begin
          memWe = 1'b1;
          memWa = wr_addr;
          memWd = wr_data;
        end
        if (clear_start) begin
          nextState = CLEAR;
          ptrNext   = '0;
        end else if (load_start) begin
          if (load_len == '0) begin
            doneNext = 1'b1;
          end else begin
            nextState = LOAD;
            ptrNext   = load_base;
            cntNext   = load_len;
          end
        end
      end
      LOAD: begin
        dropNext = wr_en;
        if (load_abort) begin
          nextState = IDLE;
        end else if (load_valid) begin
          memWe   = 1'b1;
          memWa   = ptr;
          memWd   = load_data;
          ptrNext = ptr + ADDR_W'(1);
          cntNext = cnt - (ADDR_W+1)'(1);
          if (cnt == (ADDR_W+1)'(1)) begin
            nextState = IDLE;
            doneNext  = 1'b1;
          end
        end
      end
      CLEAR: begin
        dropNext = wr_en;
        memWe    = 1'b1;
        memWa    = ptr;
        memWd    = '0;
        ptrNext  = ptr + ADDR_W'(1);
        if (ptr == ADDR_W'(DEPTH-1)) begin
          nextState = IDLE;
          doneNext  = 1'b1;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // controller state, pointer, counter and pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      done    <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      state   <= nextState;
      ptr     <= ptrNext;
      cnt     <= cntNext;
      done    <= doneNext;
      wr_drop <= dropNext;
    end
  end

  // storage array; reset zeroes every word
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (memWe) begin
      mem[memWa] <= memWd;
    end
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Parametrised multi-port instruction store for the openPIO core, generalising the fixed 32×16, five-reader program memory. It provides N asynchronous read ports for the state machines and the PIO front end. It also provides three write paths:
- a single-word direct write port;
- a burst loader with valid/ready handshake, auto-incrementing wrapping address;
- a background clear sweep.

A small controller FSM arbitrates between the write paths.

## Interface
- DATA_W, 16, instruction word width
- DEPTH, 32, number of words; power of two, ≥ 2
- N_PORTS, 5, number of asynchronous read ports
- ADDR_W, $clog2(DEPTH), address width (derived)
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- rd_addr  in  N_PORTS*ADDR_W  packed read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  N_PORTS*DATA_W  packed read data, port p at [p*DATA_W +: DATA_W]
- wr_en  in  1  direct single-word write request
- wr_addr  in  ADDR_W  direct write address
- wr_data  in  DATA_W  direct write data
- wr_drop  out  1  one-cycle pulse: a direct write was rejected because the block was busy
- load_start  in  1  start a burst load (honoured only in IDLE)
- load_base  in  ADDR_W  first burst address
- load_len  in  ADDR_W+1  number of words in the burst
- load_valid  in  1  burst word present on load_data
- load_data  in  DATA_W  burst word
- load_ready  out  1  loader accepts a word this cycle
- load_abort  in  1  terminate an active burst
- clear_start  in  1  start a zeroing sweep (honoured only in IDLE)
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse: a burst or clear completed normally

## Operation
- Reads are combinational: rd_data[p] = mem[rd_addr[p]]. Every port is independent, and ports may share an address.
- FSM states: IDLE, LOAD, CLEAR.
  - IDLE, clear_start=1 → CLEAR. The sweep pointer is set to 0.
  - IDLE, load_start=1, clear_start=0, load_len≠0 → LOAD. ptr=load_base and cnt=load_len are captured.
  - IDLE, load_start=1, load_len=0 → stay in IDLE. done pulses next cycle. No write occurs.
  - LOAD: load_ready=1. On load_valid&load_ready, mem[ptr]←load_data, ptr←ptr+1 mod DEPTH, cnt←cnt−1.
  - LOAD, last word accepted (cnt=1) → IDLE. done pulses.
  - LOAD, load_abort=1 → IDLE. No done pulse. A word presented with valid in the abort cycle is NOT written. Words already written remain.
  - CLEAR: mem[ptr]←0 and ptr increments, one word per cycle. After writing DEPTH−1 → IDLE, done pulses. load_abort is ignored in CLEAR.
- Bursts with load_len > DEPTH wrap and overwrite earlier words of the same burst. This is legal.
- Direct write is performed only when the FSM is in IDLE: mem[wr_addr]←wr_data. It is also performed in the same cycle a load or clear is started, and it lands before the sweep or burst.
- A direct write requested in LOAD or CLEAR is discarded and wr_drop pulses.
- load_start and clear_start asserted outside IDLE are ignored.
- reset: all DEPTH words ←0, FSM←IDLE, ptr and cnt ←0. The last item takes priority over all other inputs in that cycle.

## Timing
- Reset values: busy=0, load_ready=0, done=0, wr_drop=0. rd_data is all zeros after the reset edge.
- Write latency is 1 cycle. A word written at edge k is visible on rd_data after edge k. A read of the same address in the write cycle returns the old value (no bypass).
- load_start sampled at edge 0 gives busy=1 and load_ready=1 from cycle 1.
- A burst of L words with load_valid held high finishes as follows:
  - the last word is accepted in cycle L;
  - busy=0 and done=1 in cycle L+1.
- Clear started at edge 0 occupies cycles 1..DEPTH. done=1 and busy=0 in cycle DEPTH+1.
- load_len=0 gives done=1 in cycle 1, with busy low throughout.
- done and wr_drop are registered and each lasts exactly one cycle.
- load_ready is registered (state-decoded) and falls in the cycle after the last accept or an abort.
- A new start is accepted in the same cycle done is high, because the FSM is already in IDLE.

## Test plan
- Reset, then read all 5 ports at addresses 0,7,15,24,31: all data=0x0000, busy=0, load_ready=0.
- Direct write 0xA5A5@3 in IDLE with rd_addr[0]=3. Required: old value 0 in the write cycle, 0xA5A5 the next cycle. A second write attempt during LOAD leaves mem unchanged and gives wr_drop=1 for one cycle.
- Burst load_base=30, load_len=4, data 0x1111..0x4444 with valid gapped every other cycle. Required: mem[30]=0x1111, mem[31]=0x2222, mem[0]=0x3333, mem[1]=0x4444 (wrap), done one cycle after the 4th accept.
- Burst load_len=6 with load_abort asserted alongside the 3rd valid word. Required: only 2 words written, no done, busy=0 the next cycle.
- Fill memory, then clear_start together with load_start. Required: CLEAR wins, busy for 32 cycles, done in cycle 33, all words 0. Asserting reset in cycle 10 of the sweep instead gives IDLE with all memory zeroed on the next cycle.
- DEPTH=64, N_PORTS=8, DATA_W=32 instance: burst load_len=64 from base 0 gives each port reading its own distinct address the correct word.
